// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add multiply and restoring divide, with a registered flags register.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [7:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_SUM  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_LSL  = 4'h5;
  localparam logic [3:0] OP_LSR  = 4'h6;
  localparam logic [3:0] OP_ID   = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_DIVU = 4'h9;
  localparam logic [3:0] OP_REMU = 4'hA;
  localparam logic [3:0] OP_ADC  = 4'hB;
  localparam logic [3:0] OP_SBB  = 4'hC;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_isMulti;
  logic             w_lastIter;

  logic             w_cin;
  logic [WIDTH:0]   w_addRes;
  logic [WIDTH:0]   w_subRes;
  logic [WIDTH:0]   w_shlRes;
  logic [WIDTH:0]   w_shrRes;
  logic [WIDTH-1:0] w_scRes;
  logic             w_scCarry;
  logic             w_scOvf;
  logic             w_scLegal;

  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_divShift;
  logic [WIDTH-1:0] w_divDiff;
  logic             w_divOk;
  logic [WIDTH-1:0] w_iterHi;
  logic [WIDTH-1:0] w_iterLo;
  logic [WIDTH-1:0] w_mcRes;
  logic             w_mcCarry;
  logic             w_mcDivZero;

  function automatic logic [7:0] packFlags(input logic [WIDTH-1:0] res,
                                           input logic carry,
                                           input logic ovf,
                                           input logic divZero);
    packFlags = {2'b00, divZero, ~^res, (res == '0), ovf, res[WIDTH-1], carry};
  endfunction

  assign in_ready   = (r_state == IDLE);
  assign w_accept   = in_valid & in_ready;
  assign w_isMulti  = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  assign w_lastIter = (r_state == BUSY) && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_isMulti) w_nextState = BUSY;
      BUSY:    if (w_lastIter) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Shifting an extra guard bit through makes the last bit shifted out fall
  // into the guard position, and any amount >= WIDTH naturally yields zero.
  assign w_cin    = flags[0] & ((op == OP_ADC) || (op == OP_SBB));
  assign w_addRes = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
  assign w_subRes = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_cin};
  assign w_shlRes = {1'b0, a} << b;
  assign w_shrRes = {a, 1'b0} >> b;

  always_comb begin
    w_scRes   = '0;
    w_scCarry = 1'b0;
    w_scOvf   = 1'b0;
    w_scLegal = 1'b1;
    case (op)
      OP_SUM, OP_ADC: begin
        w_scRes   = w_addRes[WIDTH-1:0];
        w_scCarry = w_addRes[WIDTH];
        w_scOvf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_addRes[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        w_scRes   = w_subRes[WIDTH-1:0];
        w_scCarry = w_subRes[WIDTH];
        w_scOvf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_subRes[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_scRes = a & b;
      OP_OR:  w_scRes = a | b;
      OP_NOT: w_scRes = ~a;
      OP_LSL: begin
        w_scRes   = w_shlRes[WIDTH-1:0];
        w_scCarry = w_shlRes[WIDTH];
      end
      OP_LSR: begin
        w_scRes   = w_shrRes[WIDTH:1];
        w_scCarry = w_shrRes[0];
      end
      OP_ID:   w_scRes = a;
      default: w_scLegal = 1'b0;
    endcase
  end

  // One iteration per busy cycle. MUL keeps {hi,lo} as the partial product
  // with the multiplier draining out of lo; DIVU/REMU keep the partial
  // remainder in hi and shift the dividend out of / quotient into lo.
  assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_divShift = {r_hi, r_lo[WIDTH-1]};
  assign w_divOk    = (w_divShift >= {1'b0, r_b});
  assign w_divDiff  = w_divShift[WIDTH-1:0] - r_b;

  always_comb begin
    w_iterHi    = r_hi;
    w_iterLo    = r_lo;
    w_mcRes     = '0;
    w_mcCarry   = 1'b0;
    w_mcDivZero = 1'b0;
    if (r_op == OP_MUL) begin
      w_iterHi  = w_mulSum[WIDTH:1];
      w_iterLo  = {w_mulSum[0], r_lo[WIDTH-1:1]};
      w_mcRes   = w_iterLo;
      w_mcCarry = (w_iterHi != '0);
    end else begin
      w_iterHi    = w_divOk ? w_divDiff : w_divShift[WIDTH-1:0];
      w_iterLo    = {r_lo[WIDTH-2:0], w_divOk};
      w_mcRes     = (r_op == OP_REMU) ? w_iterHi : w_iterLo;
      w_mcDivZero = (r_b == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= '0;
    end else begin
      out_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (w_accept) begin
          if (w_isMulti) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_hi  <= '0;
            r_lo  <= (op == OP_MUL) ? b : a;
            r_cnt <= '0;
          end else begin
            out_valid <= 1'b1;
            out       <= w_scRes;
            if (w_scLegal) flags <= packFlags(w_scRes, w_scCarry, w_scOvf, 1'b0);
          end
        end
      end else begin
        r_hi  <= w_iterHi;
        r_lo  <= w_iterLo;
        r_cnt <= r_cnt + CW'(1);
        if (w_lastIter) begin
          r_cnt     <= '0;
          out_valid <= 1'b1;
          out       <= w_mcRes;
          flags     <= packFlags(w_mcRes, w_mcCarry, w_mcCarry, w_mcDivZero);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=8 with hand-computed results.
module tb_alu_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       op = 4'h0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic [7:0]       flags;

  int checkCount = 0;
  int errorCount = 0;
  int latency;
  int pulseCount;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out(out), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one request at a negedge; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [3:0] opIn, input logic [7:0] aIn,
                               input logic [7:0] bIn);
    in_valid = 1'b1;
    op = opIn;
    a = aIn;
    b = bIn;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'hA5;
    b = 8'h3C;
  endtask

  task automatic checkResult(input string tag, input logic [7:0] expOut,
                             input logic [7:0] expFlags);
    checkOutput({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, ".out"}, {24'd0, out}, {24'd0, expOut});
    checkOutput({tag, ".flags"}, {24'd0, flags}, {24'd0, expFlags});
  endtask

  task automatic waitResult(input int maxCycles, output int lat);
    lat = 0;
    while (!out_valid && lat < maxCycles) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    $display("[TB] starting alu_seq directed test");
    repeat (2) @(negedge clk);
    checkOutput("reset.out", {24'd0, out}, 32'h0);
    checkOutput("reset.flags", {24'd0, flags}, 32'h0);
    checkOutput("reset.valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset.ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(4'h0, 8'hFF, 8'h01);
    checkResult("sumWrap", 8'h00, 8'h19);
    checkOutput("sumWrap.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    checkOutput("sumWrap.pulse", {31'd0, out_valid}, 32'd0);
    checkOutput("sumWrap.hold", {24'd0, flags}, 32'h19);

    applyStimulus(4'h1, 8'h80, 8'h01);
    checkResult("subOvf", 8'h7F, 8'h04);
    applyStimulus(4'hC, 8'h00, 8'h00);
    checkResult("sbbZero", 8'h00, 8'h18);

    applyStimulus(4'h1, 8'h00, 8'h01);
    checkResult("subBorrow", 8'hFF, 8'h13);
    applyStimulus(4'hC, 8'h05, 8'h02);
    checkResult("sbbCin", 8'h02, 8'h00);

    applyStimulus(4'h0, 8'hFF, 8'h01);
    checkResult("sumCarry", 8'h00, 8'h19);
    applyStimulus(4'hB, 8'h00, 8'h00);
    checkResult("adcCin", 8'h01, 8'h00);

    applyStimulus(4'h2, 8'hF0, 8'h3C);
    checkResult("and", 8'h30, 8'h10);
    applyStimulus(4'h3, 8'hF0, 8'h0F);
    checkResult("or", 8'hFF, 8'h12);
    applyStimulus(4'h4, 8'h0F, 8'h00);
    checkResult("not", 8'hF0, 8'h12);

    // MUL with a competing SUM held on the request lines while busy.
    applyStimulus(4'h8, 8'h10, 8'h10);
    checkOutput("mul.busyReady", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    op = 4'h0;
    a = 8'h01;
    b = 8'h01;
    waitResult(20, latency);
    checkOutput("mul.latency", latency, 32'd8);
    checkResult("mul", 8'h00, 8'h1D);
    checkOutput("mul.readyAtResult", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkResult("sumAfterMul", 8'h02, 8'h00);

    applyStimulus(4'h9, 8'd200, 8'd7);
    waitResult(20, latency);
    checkOutput("divu.latency", latency, 32'd8);
    checkResult("divu", 8'h1C, 8'h00);

    applyStimulus(4'hA, 8'd200, 8'd7);
    waitResult(20, latency);
    checkResult("remu", 8'h04, 8'h00);

    applyStimulus(4'h9, 8'h55, 8'h00);
    waitResult(20, latency);
    checkOutput("divZero.latency", latency, 32'd8);
    checkResult("divZero", 8'hFF, 8'h32);

    applyStimulus(4'hA, 8'h55, 8'h00);
    waitResult(20, latency);
    checkResult("remZero", 8'h55, 8'h30);

    applyStimulus(4'h6, 8'h81, 8'd8);
    checkResult("lsrWidth", 8'h00, 8'h19);
    applyStimulus(4'h6, 8'h81, 8'd9);
    checkResult("lsrOver", 8'h00, 8'h18);
    applyStimulus(4'h5, 8'h81, 8'd1);
    checkResult("lsl1", 8'h02, 8'h01);
    applyStimulus(4'hE, 8'h12, 8'h34);
    checkResult("illegal", 8'h00, 8'h01);

    applyStimulus(4'h7, 8'h5A, 8'h00);
    checkResult("id", 8'h5A, 8'h10);

    // Abort a MUL partway through with reset.
    applyStimulus(4'h8, 8'h03, 8'h05);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort.out", {24'd0, out}, 32'h0);
    checkOutput("abort.flags", {24'd0, flags}, 32'h0);
    checkOutput("abort.valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulseCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) pulseCount++;
    end
    checkOutput("abort.noPulse", pulseCount, 32'd0);
    checkOutput("abort.ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(4'h0, 8'h03, 8'h04);
    checkResult("sumAfterReset", 8'h07, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
